// File: rtl/skinny_mask_pkg.sv
// Shared definitions for the masked Skinny S-box: driver FSM states, S-box sizing,
// share-pair payload and the unmasked reference S-box table.
package skinny_mask_pkg;

  localparam int unsigned SBOX_LATENCY = 9;
  localparam int unsigned SBOX_FRESH_W = 17;
  localparam int unsigned NIBBLE_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  // Two Boolean shares of one nibble; the value is s0 ^ s1.
  typedef struct packed {
    logic [NIBBLE_W-1:0] s0;
    logic [NIBBLE_W-1:0] s1;
  } share_t;

  localparam logic [NIBBLE_W-1:0] SKINNY_SBOX [16] = '{
    4'hc, 4'h6, 4'h9, 4'h0, 4'h1, 4'ha, 4'h2, 4'hb,
    4'h3, 4'h8, 4'h5, 4'hd, 4'h4, 4'he, 4'h7, 4'hf
  };

  function automatic logic [NIBBLE_W-1:0] skinny_sbox(input logic [NIBBLE_W-1:0] x);
    return SKINNY_SBOX[x];
  endfunction

endpackage

// File: rtl/skinny_sbox_hpc2_driver.sv
// Control stage for the masked HPC2 Skinny S-box: masks one nibble into two shares,
// restarts the S-box gating controller, waits for Synch and hands the output shares on.
module skinny_sbox_hpc2_driver
  import skinny_mask_pkg::*;
#(
  parameter int unsigned LATENCY   = SBOX_LATENCY,
  parameter int unsigned FRESH_W   = SBOX_FRESH_W,
  parameter int unsigned WD_MARGIN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_data,
  input  logic [3:0]         in_mask,
  input  logic [FRESH_W-1:0] in_fresh,
  output logic [3:0]         si_s0,
  output logic [3:0]         si_s1,
  output logic [FRESH_W-1:0] fresh,
  output logic               sbox_rst,
  input  logic               sbox_synch,
  input  logic [3:0]         so_s0,
  input  logic [3:0]         so_s1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_s0,
  output logic [3:0]         out_s1,
  output logic               err
);

  localparam int unsigned WD_LIMIT = LATENCY + WD_MARGIN;
  localparam int unsigned CNT_W    = $clog2(WD_LIMIT);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  share_t             si_q, si_d;
  share_t             so_q, so_d;
  logic [FRESH_W-1:0] fresh_q, fresh_d;
  logic               in_ready_q, in_ready_d;
  logic               sbox_rst_q, sbox_rst_d;
  logic               out_valid_q, out_valid_d;
  logic               err_q, err_d;

  // State and output registers; reset holds the S-box controller in restart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      si_q        <= '0;
      so_q        <= '0;
      fresh_q     <= '0;
      in_ready_q  <= 1'b1;
      sbox_rst_q  <= 1'b1;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      si_q        <= si_d;
      so_q        <= so_d;
      fresh_q     <= fresh_d;
      in_ready_q  <= in_ready_d;
      sbox_rst_q  <= sbox_rst_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic; every register update is decided here so outputs stay registered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    si_d        = si_q;
    so_d        = so_q;
    fresh_d     = fresh_q;
    in_ready_d  = in_ready_q;
    sbox_rst_d  = sbox_rst_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        sbox_rst_d = 1'b0;
        if (in_valid && in_ready_q) begin
          si_d.s0    = in_data ^ in_mask;
          si_d.s1    = in_mask;
          fresh_d    = in_fresh;
          in_ready_d = 1'b0;
          sbox_rst_d = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        sbox_rst_d = 1'b0;
        cnt_d      = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Synch takes priority over a coincident watchdog expiry.
        if (sbox_synch) begin
          so_d.s0     = so_s0;
          so_d.s1     = so_s1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (cnt_q == CNT_W'(WD_LIMIT - 1)) begin
          err_d      = 1'b1;
          in_ready_d = 1'b1;
          state_d    = IDLE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign si_s0     = si_q.s0;
  assign si_s1     = si_q.s1;
  assign fresh     = fresh_q;
  assign sbox_rst  = sbox_rst_q;
  assign out_valid = out_valid_q;
  assign out_s0    = so_q.s0;
  assign out_s1    = so_q.s1;
  assign err       = err_q;

endmodule

// File: tb/tb_skinny_sbox_hpc2_driver.sv
// Bench for skinny_sbox_hpc2_driver with a behavioural stand-in for the gated HPC2 S-box.
module tb_skinny_sbox_hpc2_driver;
  import skinny_mask_pkg::*;

  localparam int unsigned LATENCY = SBOX_LATENCY;
  localparam int unsigned FRESH_W = SBOX_FRESH_W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [3:0]         in_data = '0;
  logic [3:0]         in_mask = '0;
  logic [FRESH_W-1:0] in_fresh = '0;
  logic [3:0]         si_s0, si_s1;
  logic [FRESH_W-1:0] fresh;
  logic               sbox_rst;
  logic               sbox_synch;
  logic [3:0]         so_s0, so_s1;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [3:0]         out_s0, out_s1;
  logic               err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_q [$];
  logic [3:0] exp_sbox [16];

  // S-box stand-in: Synch on the LATENCY-th cycle after restart release.
  logic       synch_en = 1'b1;
  logic       synch_force = 1'b0;
  logic [3:0] so_pert = '0;
  logic [3:0] scnt;

  always_ff @(posedge clk) begin
    if (sbox_rst) scnt <= '0;
    else if (scnt != 4'hf) scnt <= scnt + 4'd1;
  end

  assign sbox_synch = (synch_en && scnt == 4'(LATENCY - 1)) || synch_force;
  assign so_s1      = fresh[3:0] ^ so_pert;
  assign so_s0      = skinny_sbox(si_s0 ^ si_s1) ^ fresh[3:0] ^ so_pert;

  skinny_sbox_hpc2_driver dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mask    (in_mask),
    .in_fresh   (in_fresh),
    .si_s0      (si_s0),
    .si_s1      (si_s1),
    .fresh      (fresh),
    .sbox_rst   (sbox_rst),
    .sbox_synch (sbox_synch),
    .so_s0      (so_s0),
    .so_s1      (so_s1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_s0     (out_s0),
    .out_s1     (out_s1),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops one expected nibble per output handshake.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
      else check("out_recomb", 32'(out_s0 ^ out_s1), 32'(exp_q.pop_front()));
    end
  end

  task automatic send(input logic [3:0] d, input logic [3:0] m,
                      input logic [FRESH_W-1:0] f, input bit push);
    int k;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_mask  = m;
    in_fresh = f;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    if (push) exp_q.push_back(exp_sbox[d]);
    #1 in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid, optionally checking share stability.
  task automatic wait_out(input logic [3:0] s0e, input logic [3:0] s1e, input bit chk,
                          output int edges);
    edges = 0;
    while (!out_valid && edges < 40) begin
      if (chk) begin
        check("si_s0_hold", 32'(si_s0), 32'(s0e));
        check("si_s1_hold", 32'(si_s1), 32'(s1e));
      end
      @(posedge clk);
      #1 edges++;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!in_ready && k < 40) begin
      @(posedge clk);
      #1 k++;
    end
    check("return_idle", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [3:0] o0, o1, m;
    exp_sbox = '{4'hc, 4'h6, 4'h9, 4'h0, 4'h1, 4'ha, 4'h2, 4'hb,
                 4'h3, 4'h8, 4'h5, 4'hd, 4'h4, 4'he, 4'h7, 4'hf};

    #2 rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sbox_rst", 32'(sbox_rst), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    check("rst_si", 32'({si_s0, si_s1}), 32'd0);
    check("rst_fresh", 32'(fresh), 32'd0);
    check("rst_out_s", 32'({out_s0, out_s1}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check("idle_sbox_rst", 32'(sbox_rst), 32'd0);

    // 1: zero nibble, latency and share hold
    send(4'h0, 4'h5, 17'h1a5a3, 1'b1);
    check("t1_in_ready_drop", 32'(in_ready), 32'd0);
    check("t1_fresh", 32'(fresh), 32'h1a5a3);
    wait_out(4'h5, 4'h5, 1'b1, lat);
    check("t1_latency", 32'(lat), 32'd10);
    check("t1_recomb", 32'(out_s0 ^ out_s1), 32'hc);
    check("t1_si_done", 32'({si_s0, si_s1}), 32'h55);
    wait_idle();

    // 2: full sweep with random masks
    for (int d = 0; d < 16; d++) begin
      m = 4'($urandom);
      send(4'(d), m, 17'($urandom), 1'b1);
      wait_out(4'(d) ^ m, m, 1'b1, lat);
      check("t2_latency", 32'(lat), 32'd10);
      wait_idle();
    end

    // 3: downstream backpressure
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(4'h7, 4'h9, 17'h0f0f3, 1'b1);
    wait_out(4'he, 4'h9, 1'b1, lat);
    check("t3_latency", 32'(lat), 32'd10);
    o0 = out_s0;
    o1 = out_s1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("t3_valid_hold", 32'(out_valid), 32'd1);
      check("t3_out_hold", 32'({out_s0, out_s1}), 32'({o0, o1}));
      check("t3_in_ready_low", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t3_in_ready_after_hs", 32'(in_ready), 32'd1);
    check("t3_valid_drop", 32'(out_valid), 32'd0);

    // 6: Synch outside WAIT is ignored (IDLE, then DONE)
    @(negedge clk);
    so_pert     = 4'ha;
    synch_force = 1'b1;
    @(negedge clk);
    synch_force = 1'b0;
    so_pert     = 4'h0;
    @(posedge clk);
    #1;
    check("t6_idle_out_s", 32'({out_s0, out_s1}), 32'({o0, o1}));
    check("t6_idle_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    send(4'h2, 4'h3, 17'h12345, 1'b1);
    wait_out(4'h1, 4'h3, 1'b0, lat);
    o0 = out_s0;
    o1 = out_s1;
    @(negedge clk);
    so_pert     = 4'h5;
    synch_force = 1'b1;
    repeat (2) @(negedge clk);
    synch_force = 1'b0;
    so_pert     = 4'h0;
    @(posedge clk);
    #1;
    check("t6_done_out_s", 32'({out_s0, out_s1}), 32'({o0, o1}));
    check("t6_done_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("t6_no_spurious", 32'(out_valid), 32'd0);

    // 4: watchdog on missing Synch
    synch_en = 1'b0;
    send(4'h4, 4'h3, 17'h00abc, 1'b0);
    lat = 0;
    while (!err && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    check("t4_err_edges", 32'(lat), 32'd14);
    check("t4_err", 32'(err), 32'd1);
    check("t4_idle", 32'(in_ready), 32'd1);
    check("t4_no_valid", 32'(out_valid), 32'd0);
    synch_en = 1'b1;
    send(4'h5, 4'h8, 17'h1ffff, 1'b1);
    wait_out(4'hd, 4'h8, 1'b0, lat);
    check("t4_after_latency", 32'(lat), 32'd10);
    check("t4_err_sticky", 32'(err), 32'd1);
    wait_idle();

    // 5: reset in WAIT cycle 4 aborts the evaluation
    send(4'h3, 4'h6, 17'h0aaaa, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_sbox_rst", 32'(sbox_rst), 32'd1);
    check("t5_err", 32'(err), 32'd0);
    check("t5_si", 32'({si_s0, si_s1}), 32'd0);
    check("t5_fresh", 32'(fresh), 32'd0);
    check("t5_out_s", 32'({out_s0, out_s1}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    send(4'hf, 4'hb, 17'h15555, 1'b1);
    wait_out(4'h4, 4'hb, 1'b1, lat);
    check("t5_latency", 32'(lat), 32'd10);
    wait_idle();

    repeat (30) @(posedge clk);
    #1 check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
